// File: rtl/dpd_cadder_arb_if.sv
// Bus bundle between the round-robin arbiter, its requesters, the shared
// 8-input complex adder and the result consumer.
interface dpd_cadder_arb_if #(
  parameter int DWIDTH = 16,
  parameter int NREQ   = 4
);
  localparam int IDW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
  localparam int SW  = 2 * DWIDTH;
  localparam int RW  = 2 * (DWIDTH + 3);

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*16*DWIDTH-1:0] req_data;

  logic                      add_din_enable;
  logic [SW-1:0]             add_din0;
  logic [SW-1:0]             add_din1;
  logic [SW-1:0]             add_din2;
  logic [SW-1:0]             add_din3;
  logic [SW-1:0]             add_din4;
  logic [SW-1:0]             add_din5;
  logic [SW-1:0]             add_din6;
  logic [SW-1:0]             add_din7;
  logic                      add_dout_valid;
  logic [RW-1:0]             add_dout;

  logic                      res_valid;
  logic [IDW-1:0]            res_id;
  logic [RW-1:0]             res_data;

  modport slave (
    input  req_valid, req_data, add_dout_valid, add_dout,
    output req_ready, add_din_enable,
           add_din0, add_din1, add_din2, add_din3,
           add_din4, add_din5, add_din6, add_din7,
           res_valid, res_id, res_data
  );

  modport master (
    output req_valid, req_data, add_dout_valid, add_dout,
    input  req_ready, add_din_enable,
           add_din0, add_din1, add_din2, add_din3,
           add_din4, add_din5, add_din6, add_din7,
           res_valid, res_id, res_data
  );
endinterface

// File: rtl/dpd_cadder_arb.sv
// Round-robin arbiter time-sharing one 8-input complex adder among NREQ
// requesters; a tag pipeline matched to the adder latency returns result IDs.
module dpd_cadder_arb #(
  parameter int DWIDTH = 16,
  parameter int NREQ   = 4,
  parameter int LAT    = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_enable,
  input  logic                     err_clr,
  dpd_cadder_arb_if.slave          bus,
  output logic                     busy,
  output logic [$clog2(LAT+3)-1:0] inflight,
  output logic                     err_sync
);
  localparam int IDW  = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
  localparam int SW   = 2 * DWIDTH;
  localparam int OPW  = 8 * SW;
  localparam int RW   = 2 * (DWIDTH + 3);
  localparam int CNTW = $clog2(LAT + 3);

  logic [IDW-1:0]  ptr_reg;
  logic [IDW-1:0]  ptr_next;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_id;
  logic            xfer;
  logic [IDW:0]    idx_ext;
  logic [IDW-1:0]  idx;

  logic [OPW-1:0]  slice [NREQ];
  logic [OPW-1:0]  win_slice;
  logic [SW-1:0]   win_samp [8];

  logic            din_en_reg;
  logic [IDW-1:0]  din_id_reg;
  logic [SW-1:0]   op_reg [8];

  logic            tag_v_reg  [LAT];
  logic [IDW-1:0]  tag_id_reg [LAT];
  logic            tag_v_out;
  logic            hit;

  logic            res_valid_reg;
  logic [IDW-1:0]  res_id_reg;
  logic [RW-1:0]   res_data_reg;
  logic            err_reg;
  logic [CNTW-1:0] inflight_reg;
  logic [CNTW-1:0] inflight_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = bus.req_data[gi*OPW +: OPW];
    end
  endgenerate

  // Rotating-priority search starting at ptr; reset forces no grant.
  always_comb begin
    grant   = '0;
    win_id  = '0;
    xfer    = 1'b0;
    idx_ext = '0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx_ext = {1'b0, ptr_reg} + (IDW+1)'(i);
      if (idx_ext >= (IDW+1)'(NREQ))
        idx_ext = idx_ext - (IDW+1)'(NREQ);
      idx = idx_ext[IDW-1:0];
      if (!xfer && cfg_enable && rst_n && bus.req_valid[idx]) begin
        xfer        = 1'b1;
        grant[idx]  = 1'b1;
        win_id      = idx;
      end
    end
  end

  assign bus.req_ready = grant;
  assign ptr_next      = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
  assign win_slice     = slice[win_id];

  generate
    for (gi = 0; gi < 8; gi++) begin : g_samp
      assign win_samp[gi] = win_slice[gi*SW +: SW];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg    <= '0;
      din_en_reg <= 1'b0;
      din_id_reg <= '0;
      for (int k = 0; k < 8; k++) op_reg[k] <= '0;
    end else begin
      din_en_reg <= xfer;
      if (xfer) begin
        ptr_reg    <= ptr_next;
        din_id_reg <= win_id;
        for (int k = 0; k < 8; k++) op_reg[k] <= win_samp[k];
      end
    end
  end

  assign bus.add_din_enable = din_en_reg;
  assign bus.add_din0 = op_reg[0];
  assign bus.add_din1 = op_reg[1];
  assign bus.add_din2 = op_reg[2];
  assign bus.add_din3 = op_reg[3];
  assign bus.add_din4 = op_reg[4];
  assign bus.add_din5 = op_reg[5];
  assign bus.add_din6 = op_reg[6];
  assign bus.add_din7 = op_reg[7];

  // Stage 0 follows the adder strobe, so the last stage meets add_dout_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) begin
        tag_v_reg[s]  <= 1'b0;
        tag_id_reg[s] <= '0;
      end
    end else begin
      tag_v_reg[0]  <= din_en_reg;
      tag_id_reg[0] <= din_id_reg;
      for (int s = 1; s < LAT; s++) begin
        tag_v_reg[s]  <= tag_v_reg[s-1];
        tag_id_reg[s] <= tag_id_reg[s-1];
      end
    end
  end

  assign tag_v_out = tag_v_reg[LAT-1];
  assign hit       = tag_v_out & bus.add_dout_valid;

  always_comb begin
    inflight_next = inflight_reg;
    if (xfer && !res_valid_reg)
      inflight_next = inflight_reg + CNTW'(1);
    else if (!xfer && res_valid_reg)
      inflight_next = inflight_reg - CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_reg <= 1'b0;
      res_id_reg    <= '0;
      res_data_reg  <= '0;
      err_reg       <= 1'b0;
      inflight_reg  <= '0;
    end else begin
      res_valid_reg <= hit;
      if (hit) begin
        res_id_reg   <= tag_id_reg[LAT-1];
        res_data_reg <= bus.add_dout;
      end
      // A fresh misalignment beats a simultaneous clear.
      if (tag_v_out != bus.add_dout_valid)
        err_reg <= 1'b1;
      else if (err_clr)
        err_reg <= 1'b0;
      inflight_reg <= inflight_next;
    end
  end

  assign bus.res_valid = res_valid_reg;
  assign bus.res_id    = res_id_reg;
  assign bus.res_data  = res_data_reg;
  assign inflight      = inflight_reg;
  assign busy          = (inflight_reg != '0);
  assign err_sync      = err_reg;
endmodule

// File: tb/tb_dpd_cadder_arb.sv
// Bench for dpd_cadder_arb: adder model, queue-based result model checked
// every cycle, plus directed scenarios with hand-computed literals.
module tb_dpd_cadder_arb;
  localparam int DWIDTH = 16;
  localparam int NREQ   = 4;
  localparam int LAT    = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_enable;
  logic       err_clr;
  logic       busy;
  logic [3:0] inflight;
  logic       err_sync;
  logic       late;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  dpd_cadder_arb_if #(.DWIDTH(DWIDTH), .NREQ(NREQ)) bus ();

  dpd_cadder_arb #(.DWIDTH(DWIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_enable (cfg_enable),
    .err_clr    (err_clr),
    .bus        (bus),
    .busy       (busy),
    .inflight   (inflight),
    .err_sync   (err_sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [37:0] sum8(input logic [255:0] s);
    logic signed [18:0] si, sq;
    logic signed [15:0] a, b;
    si = '0;
    sq = '0;
    for (int k = 0; k < 8; k++) begin
      a  = s[k*32+16 +: 16];
      b  = s[k*32 +: 16];
      si = si + {{3{a[15]}}, a};
      sq = sq + {{3{b[15]}}, b};
    end
    return {si, sq};
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] i, input logic [15:0] q);
    return {8{i, q}};
  endfunction

  // Stand-in for the cadder8: LAT-cycle pipeline, optionally one cycle late.
  logic [LAT+1:1] apv;
  logic [37:0]    apd [1:LAT+1];
  logic [255:0]   din_vec;
  assign din_vec = {bus.add_din7, bus.add_din6, bus.add_din5, bus.add_din4,
                    bus.add_din3, bus.add_din2, bus.add_din1, bus.add_din0};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apv <= '0;
      for (int k = 1; k <= LAT+1; k++) apd[k] <= '0;
    end else begin
      apv[1] <= bus.add_din_enable;
      apd[1] <= sum8(din_vec);
      for (int k = 2; k <= LAT+1; k++) begin
        apv[k] <= apv[k-1];
        apd[k] <= apd[k-1];
      end
    end
  end
  assign bus.add_dout_valid = late ? apv[LAT+1] : apv[LAT];
  assign bus.add_dout       = late ? apd[LAT+1] : apd[LAT];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: every grant becomes a pending result due 9 cycles later.
  typedef struct {
    int          issue;
    int          due;
    logic [1:0]  id;
    logic [37:0] data;
    bit          late;
  } item_t;
  item_t q[$];
  item_t it;
  int          ptr_m;
  int          win;
  int          idx;
  logic [3:0]  exp_g;
  bit          prev_xfer_m;
  bit          err_m;
  bit          mism;

  initial begin
    ptr_m       = 0;
    prev_xfer_m = 1'b0;
    err_m       = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        ptr_m       = 0;
        prev_xfer_m = 1'b0;
        err_m       = 1'b0;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_add_din_enable", bus.add_din_enable, 0);
        chk("rst_add_din0", bus.add_din0, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_sync", err_sync, 0);
      end else begin
        exp_g = '0;
        win   = -1;
        if (cfg_enable) begin
          for (int i = 0; i < NREQ; i++) begin
            idx = (ptr_m + i) % NREQ;
            if (win < 0 && bus.req_valid[idx]) begin
              win        = idx;
              exp_g[idx] = 1'b1;
            end
          end
        end
        chk("m_req_ready", bus.req_ready, exp_g);
        chk("m_add_din_enable", bus.add_din_enable, prev_xfer_m);
        chk("m_inflight", inflight, q.size());
        chk("m_busy", busy, q.size() != 0);
        chk("m_err_sync", err_sync, err_m);
        if (q.size() != 0 && !q[0].late && q[0].due == cyc) begin
          chk("m_res_valid", bus.res_valid, 1);
          chk("m_res_id", bus.res_id, q[0].id);
          chk("m_res_data", bus.res_data, q[0].data);
          void'(q.pop_front());
        end else begin
          chk("m_res_valid", bus.res_valid, 0);
        end
        mism = 1'b0;
        foreach (q[j])
          if (q[j].late && (q[j].issue + 8 == cyc || q[j].issue + 9 == cyc))
            mism = 1'b1;
        err_m       = mism | (err_m & !err_clr);
        prev_xfer_m = (win >= 0);
        if (win >= 0) begin
          it.issue = cyc;
          it.due   = cyc + LAT + 2;
          it.id    = 2'(win);
          it.data  = sum8(bus.req_data[win*256 +: 256]);
          it.late  = late;
          q.push_back(it);
          ptr_m = (win + 1) % NREQ;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    bus.req_valid = '0;
    late = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n;
  int cnt;

  initial begin
    rst_n         = 1'b0;
    cfg_enable    = 1'b1;
    err_clr       = 1'b0;
    late          = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_data  = '0;
    smp();
    chk("reset_ready_gated", bus.req_ready, 0);
    step();
    bus.req_valid = '0;
    step();
    rst_n = 1'b1;

    // Single request from 2 at cycle 10 after reset
    repeat (9) step();
    step();
    bus.req_valid = 4'b0100;
    bus.req_data[2*256 +: 256] = fill(16'd1, 16'hFFFF);
    smp();
    chk("single_ready", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    smp();
    chk("single_inflight_t1", inflight, 1);
    repeat (7) step();
    step();
    smp();
    chk("single_res_valid", bus.res_valid, 1);
    chk("single_res_id", bus.res_id, 2);
    chk("single_res_data", bus.res_data, {19'h00008, 19'h7FFF8});
    chk("single_inflight_t9", inflight, 1);
    step();
    smp();
    chk("single_inflight_t10", inflight, 0);
    chk("single_busy_t10", busy, 0);

    // Four requesters continuously valid for 8 cycles
    do_reset();
    for (int r = 0; r < NREQ; r++)
      bus.req_data[r*256 +: 256] = fill(16'(100 * (r + 1)), 16'(-(r + 3)));
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) bus.req_valid = 4'hF;
      smp();
      chk("rr_grant", bus.req_ready, 64'(1) << (k % 4));
    end
    step();
    bus.req_valid = '0;
    smp();
    chk("rr_peak_inflight", inflight, 8);
    for (int k = 0; k < 8; k++) begin
      step();
      smp();
      chk("rr_res_valid", bus.res_valid, 1);
      chk("rr_res_id", bus.res_id, k % 4);
    end

    // Extreme operands from requester 1
    step();
    bus.req_valid = 4'b0010;
    bus.req_data[1*256 +: 256] = fill(16'h8000, 16'h7FFF);
    smp();
    chk("ext_ready", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    repeat (7) step();
    step();
    smp();
    chk("ext_res_valid", bus.res_valid, 1);
    chk("ext_res_data", bus.res_data, {19'h40000, 19'h3FFF8});

    // cfg_enable dropped one cycle after three grants
    step();
    bus.req_valid = 4'hF;
    smp();
    step();
    smp();
    step();
    smp();
    step();
    cfg_enable = 1'b0;
    smp();
    chk("cfg_off_ready", bus.req_ready, 0);
    step();
    smp();
    chk("cfg_off_ready2", bus.req_ready, 0);
    step();
    bus.req_valid = '0;
    cnt = 0;
    for (n = 6; n <= 14; n++) begin
      step();
      smp();
      if (bus.res_valid) cnt++;
      if (n == 11) chk("cfg_busy_last", busy, 1);
      if (n == 12) chk("cfg_busy_fall", busy, 0);
    end
    chk("cfg_result_count", cnt, 3);
    cfg_enable = 1'b1;

    // Reset four cycles after a grant from 2 (pointer would then sit at 3)
    step();
    bus.req_valid = 4'b0100;
    bus.req_data[2*256 +: 256] = fill(16'd5, 16'd5);
    smp();
    chk("rstmid_ready", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    step();
    step();
    step();
    rst_n = 1'b0;
    smp();
    chk("rstmid_inflight", inflight, 0);
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      smp();
      if (bus.res_valid) cnt++;
    end
    chk("rstmid_no_results", cnt, 0);
    step();
    bus.req_valid = 4'b1010;
    bus.req_data[1*256 +: 256] = fill(16'd7, 16'hFFF9);
    smp();
    chk("rstmid_ptr_zero", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    repeat (10) step();

    // Adder answers one cycle late
    late = 1'b1;
    step();
    bus.req_valid = 4'b0001;
    bus.req_data[0 +: 256] = fill(16'd2, 16'd3);
    smp();
    chk("late_ready", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = '0;
    repeat (6) step();
    step();
    smp();
    chk("late_err_t8", err_sync, 0);
    step();
    smp();
    chk("late_err_t9", err_sync, 1);
    step();
    step();
    step();
    smp();
    chk("late_err_sticky", err_sync, 1);
    chk("late_no_result", bus.res_valid, 0);
    step();
    err_clr = 1'b1;
    smp();
    step();
    err_clr = 1'b0;
    smp();
    chk("late_err_cleared", err_sync, 0);
    chk("late_inflight_stuck", inflight, 1);
    do_reset();
    step();
    smp();
    chk("final_inflight", inflight, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dpd_cadder_arb.md
# dpd_cadder_arb

Round-robin arbiter that time-shares one 8-input complex adder (`cadder8`) among `NREQ` requesters in the DPD actuator datapath. Each requester presents a full 8-sample complex operand set with a valid/ready handshake. The arbiter grants at most one requester per cycle and registers the winner's operands into the adder. A tag pipeline matched to the adder latency routes each result back with the requester ID. It also tracks in-flight operations and flags valid/tag misalignment.

## Interface
- `DWIDTH`, 16, component width of I and Q input samples.
- `NREQ`, 4, number of requesters (2..8).
- `LAT`, 7, adder latency in cycles from `add_din_enable` to `add_dout_valid`.
- `IDW`, derived as max(1, clog2(`NREQ`)), requester ID width (localparam).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_enable` in 1: when high, new grants are allowed.
- `err_clr` in 1: synchronous clear of `err_sync`.
- `req_valid` in `NREQ`: per-requester operand valid.
- `req_ready` out `NREQ`: per-requester grant, one-hot or zero.
- `req_data` in `NREQ*16*DWIDTH`: requester r occupies slice [r*16*DWIDTH +: 16*DWIDTH]. Within a slice, sample k is {i,q} at [k*2*DWIDTH +: 2*DWIDTH].
- `add_din_enable` out 1: strobe to adder.
- `add_din0`..`add_din7` out 2*DWIDTH each: {i,q} operands to adder.
- `add_dout_valid` in 1: valid from adder.
- `add_dout` in 2*(DWIDTH+3): {i,q} sum from adder.
- `res_valid` out 1: result strobe.
- `res_id` out `IDW`: requester ID of the result.
- `res_data` out 2*(DWIDTH+3): registered copy of `add_dout`.
- `busy` out 1: high while any operation is in flight.
- `inflight` out clog2(`LAT`+3): number of operations issued but not yet returned on `res_valid`.
- `err_sync` out 1: sticky misalignment flag.

## Operation
- **Grant:** `req_ready[r]` is combinational from `req_valid`, `cfg_enable`, and pointer `ptr`.
  - Search order is `ptr`, `ptr+1`, … mod `NREQ`.
  - The first requester with `req_valid` high wins, provided `cfg_enable` is high.
  - A transfer occurs when `req_valid[r]` and `req_ready[r]` are both high.
- **Pointer update:** on a transfer, `ptr` <= (winner+1) mod `NREQ`. With no transfer, `ptr` holds.
- **Operand register:** on a transfer, the winner's 8 samples are registered into `add_din0`..7, `add_din_enable` <= 1, and the winner ID enters the tag pipeline.
  - With no transfer, `add_din_enable` <= 0 and the operands hold their previous values.
- **Tag pipeline:** `LAT` stages of {valid, id}, all reset to 0, shifting every cycle.
  - Stage `LAT` aligns with `add_dout_valid`.
- **Output register:** `res_valid` <= tag valid AND `add_dout_valid`; `res_id` <= tag id; `res_data` <= `add_dout`.
  - `res_id` and `res_data` update only when `res_valid` is set next; otherwise they hold.
- **Misalignment check:** `err_sync` <= 1 when the tag valid and `add_dout_valid` differ at the output stage. It clears only on `err_clr` or reset; if a set and `err_clr` coincide, the set wins.
- **In-flight counter:** `inflight` increments on each transfer and decrements on each `res_valid`. Both events in the same cycle leave it unchanged. `busy` = (`inflight` != 0).
- **`cfg_enable` deasserted mid-stream:** no further grants. In-flight operations complete normally and `busy` falls after the last `res_valid`.
- **Results have no back-pressure.** Consumers must accept `res_valid` pulses at full rate.
- **Reset mid-operation** (applies to this block and the adder, which share `rst_n`):
  - All in-flight results are discarded.
  - Outputs return to their reset values.
  - `ptr` returns to 0.

## Timing
- **Reset values:** `req_ready` 0, `add_din_enable` 0, `add_din*` 0, `res_valid` 0, `res_id` 0, `res_data` 0, `busy` 0, `inflight` 0, `err_sync` 0.
- **Latency:** a transfer at cycle T gives `add_din_enable` at T+1, `add_dout_valid` at T+1+`LAT`, and `res_valid` at T+2+`LAT`. With defaults, `res_valid` arrives at T+9.
- **Throughput:** one transfer per cycle sustained. Maximum `inflight` is `LAT`+2.
- **Fairness:** with all `NREQ` requesters continuously valid, grants rotate 0,1,…,`NREQ`-1. No requester waits more than `NREQ`-1 cycles.
- **`cfg_enable`** takes effect combinationally on `req_ready` in the same cycle.

## Test plan
- **Single request:** reset, then req 2 valid at cycle 10 with all samples i=1, q=-1 -> `req_ready[2]` high at cycle 10; `res_valid` at cycle 19 with `res_id`=2, `res_data` i=8, q=-8; `inflight` reads 1 during cycles 11..19 and 0 from cycle 20.
- **All four requesters held valid for 8 cycles** -> grant order 0,1,2,3,0,1,2,3; `res_valid` for 8 consecutive cycles carrying IDs 0,1,2,3,0,1,2,3; `inflight` peaks at 8.
- **Extreme values:** samples all i=-32768, q=32767 -> `res_data` i=-262144, q=262136, with no wrap at 19 bits.
- **`cfg_enable` dropped one cycle after 3 grants** -> no further `req_ready`; exactly 3 results; `busy` falls the cycle after the third `res_valid`.
- **Reset mid-flight:** assert `rst_n` low 4 cycles after a grant -> no `res_valid` afterward; `inflight` 0; `ptr` 0, so the next grant goes to the lowest valid ID.
- **Misalignment injection:** adder model emits `add_dout_valid` one cycle late -> `err_sync` sets and stays set; `err_clr` pulse clears it.
